uart_rx_ctrl: RTL

Receive-side controller placed directly after the UART receiver. It sequences each received byte through a stop-bit qualification window and commits only clean frames to a first-word-fall-through FIFO with a valid/ready consumer handshake. It also maintains a saturating frame-error counter, a sticky overrun flag and a line-idle pulse for packet framing by the consumer.

---
 rtl/uart_rx_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: qualifies each received byte over a stop-bit window,
// commits clean frames to a FWFT FIFO, and tracks errors, overrun and line idle.
//
// state   | meaning
// --------+----------------------------------------------------------------
// WAIT    | no byte in flight; waiting for an rxDone rise
// CAPTURE | one cycle: latch rxData, load qualification timer, arm idle
// PEND    | byte held pending; commit on timer expiry or next rise, drop on rxErr
module uart_rx_ctrl #(
    parameter int Oversample  = 16,
    parameter int Depth       = 8,
    parameter int ErrWidth    = 8,
    parameter int IdleTimeout = 160
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic [7:0]                 rxData,
    input  logic                       rxDone,
    input  logic                       rxErr,
    input  logic                       clear,
    output logic [7:0]                 outData,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [$clog2(Depth):0]     count,
    output logic                       overrun,
    output logic [ErrWidth-1:0]        errCount,
    output logic                       idle
);

    localparam int PtrW  = $clog2(Depth);
    localparam int CntW  = PtrW + 1;
    localparam int TmrW  = (Oversample > 1) ? $clog2(Oversample) : 1;
    localparam int IdleW = $clog2(IdleTimeout);

    localparam logic [TmrW-1:0]  TmrLoad  = TmrW'(Oversample - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleTimeout - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(Depth);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PEND    = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [TmrW-1:0]   timer, timer_next;
    logic [7:0]        pending;
    logic              rx_done_q;
    logic              rx_rise;
    logic              capture;
    logic              commit;

    logic [7:0]        mem [Depth];
    logic [PtrW-1:0]   rd_ptr, wr_ptr;
    logic              push, pop, drop;
    logic [CntW-1:0]   count_next;
    logic [7:0]        out_data_next;

    logic              idle_armed;
    logic [IdleW-1:0]  idle_cnt;

    assign rx_rise = rxDone & ~rx_done_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= rxDone;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= S_WAIT;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            S_WAIT: begin
                if (rx_rise) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                capture    = 1'b1;
                timer_next = TmrLoad;
                state_next = S_PEND;
            end
            S_PEND: begin
                timer_next = timer - TmrW'(1);
                // rxErr wins over any commit in the same cycle
                if (rxErr) begin
                    state_next = S_WAIT;
                end else if (timer == '0) begin
                    commit     = 1'b1;
                    state_next = S_WAIT;
                end else if (rx_rise) begin
                    commit     = 1'b1;
                    state_next = S_CAPTURE;
                end
            end
            default: state_next = S_WAIT;
        endcase
        if (clear) begin
            state_next = S_WAIT;
            timer_next = '0;
            capture    = 1'b0;
            commit     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pending <= '0;
        end else if (capture) begin
            pending <= rxData;
        end
    end

    assign pop  = outValid & outReady & ~clear;
    assign push = commit & ((count != CntFull) | pop);
    assign drop = commit & ~push;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CntW'(1);
            2'b01:   count_next = count - CntW'(1);
            default: count_next = count;
        endcase
    end

    // Head register: when the popped entry was the last one, a same-cycle push
    // becomes the new head directly since it is not yet in the array.
    always_comb begin
        out_data_next = outData;
        if (pop) begin
            if (push && count == CntW'(1)) out_data_next = pending;
            else                           out_data_next = mem[rd_ptr + PtrW'(1)];
        end else if (push && count == '0) begin
            out_data_next = pending;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pending;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            overrun  <= 1'b0;
        end else if (clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outValid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            if (drop) overrun <= 1'b1;
            count    <= count_next;
            outValid <= (count_next != '0);
            outData  <= out_data_next;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            errCount <= '0;
        end else if (clear) begin
            errCount <= '0;
        end else if (rxErr && errCount != '1) begin
            errCount <= errCount + ErrWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            idle_armed <= 1'b0;
            idle_cnt   <= '0;
            idle       <= 1'b0;
        end else if (clear) begin
            idle_armed <= 1'b0;
            idle_cnt   <= '0;
            idle       <= 1'b0;
        end else if (capture) begin
            idle_armed <= 1'b1;
            idle_cnt   <= '0;
            idle       <= 1'b0;
        end else if (idle_armed) begin
            if (idle_cnt == IdleLast) begin
                idle_armed <= 1'b0;
                idle_cnt   <= '0;
                idle       <= 1'b1;
            end else begin
                idle_cnt   <= idle_cnt + IdleW'(1);
                idle       <= 1'b0;
            end
        end else begin
            idle <= 1'b0;
        end
    end

endmodule
